// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: rate-codes NUM_CH stored intensities into per-timestep spike vectors (serial value writes in, start/abort/num_steps control, out_spikes/out_spike_valid/done/step_count/frame_spikes out)
module spike_rate_encoder #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int STEP_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic [$clog2(NUM_CH)-1:0] in_ch,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      start,
  input  logic                      abort,
  input  logic [STEP_W-1:0]         num_steps,
  output logic [NUM_CH-1:0]         out_spikes,
  output logic                      out_spike_valid,
  output logic                      busy,
  output logic                      done,
  output logic [STEP_W-1:0]         step_count,
  output logic [15:0]               frame_spikes
);
  localparam int PW = $clog2(NUM_CH + 1);
  typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
  state_t              state_q;
  logic [DATA_W-1:0]   value_q [NUM_CH];
  logic [DATA_W-1:0]   acc_q [NUM_CH];
  logic [DATA_W:0]     sum_d [NUM_CH];
  logic [NUM_CH-1:0]   spikes_d;
  logic [NUM_CH-1:0]   spikes_q;
  logic [PW-1:0]       pop_d;
  logic [STEP_W-1:0]   n_q;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   step_d;
  logic [15:0]         frame_q;
  logic                valid_q;
  logic                done_q;
  logic                go;
  always_comb begin
    pop_d = '0;
    spikes_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_d[i] = {1'b0, acc_q[i]} + {1'b0, value_q[i]};
      spikes_d[i] = sum_d[i][DATA_W];
      pop_d = pop_d + PW'(sum_d[i][DATA_W]);
    end
  end
  assign step_d          = step_q + STEP_W'(1);
  assign go              = start && enable && !abort;
  assign in_ready        = state_q != ENCODE;
  assign busy            = state_q == ENCODE;
  assign out_spikes      = spikes_q;
  assign out_spike_valid = valid_q;
  assign done            = done_q;
  assign step_count      = step_q;
  assign frame_spikes    = frame_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < NUM_CH; i++) begin
        value_q[i] <= '0;
        acc_q[i]   <= '0;
      end
      spikes_q <= '0;
      n_q      <= '0;
      step_q   <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q  <= state_q == DONE;
      valid_q <= 1'b0;
      if (in_valid && in_ready) value_q[in_ch] <= in_data;
      case (state_q)
        ENCODE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (enable) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= sum_d[i][DATA_W-1:0];
            spikes_q <= spikes_d;
            valid_q  <= 1'b1;
            step_q   <= step_d;
            frame_q  <= frame_q + 16'(pop_d);
            if (step_d == n_q) state_q <= DONE;
          end
        end
        default: begin
          state_q <= go ? ((num_steps == '0) ? DONE : ENCODE) : IDLE;
          if (go) begin
            n_q      <= num_steps;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
            spikes_q <= '0;
            step_q   <= '0;
            frame_q  <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: scoreboard bench for spike_rate_encoder
module tb_spike_rate_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_ch = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_steps = '0;
  logic [7:0]  out_spikes;
  logic        out_spike_valid;
  logic        busy;
  logic        done;
  logic [7:0]  step_count;
  logic [15:0] frame_spikes;
  int          vectors = 0;
  int          miscompares = 0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  int          ch_cnt [8];
  int          exp_total = 0;
  logic [7:0]  vals [8];
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_e;
  always #5 clk = ~clk;
  spike_rate_encoder dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .in_ready(in_ready), .start(start), .abort(abort),
    .num_steps(num_steps), .out_spikes(out_spikes), .out_spike_valid(out_spike_valid),
    .busy(busy), .done(done), .step_count(step_count), .frame_spikes(frame_spikes)
  );
  always @(negedge clk) begin
    if (!rst) begin
      if (out_spike_valid) begin
        strobe_cnt++;
        for (int i = 0; i < 8; i++) ch_cnt[i] += int'(out_spikes[i]);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL strobe: got vector %b, none expected", out_spikes);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_spikes !== mon_e) begin
            miscompares++;
            $display("FAIL spikes: got %b, expected %b", out_spikes, mon_e);
          end
        end
      end
      if (done) done_cnt++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, strobes=%0d expected_pending=%0d", strobe_cnt, exp_q.size());
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    @(negedge clk);
    #1;
  endtask
  task automatic clear_counts;
    strobe_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) ch_cnt[i] = 0;
  endtask
  task automatic wr(input int ch, input logic [7:0] d, input bit upd);
    in_valid = 1'b1;
    in_ch = 3'(ch);
    in_data = d;
    tick();
    in_valid = 1'b0;
    if (upd) vals[ch] = d;
  endtask
  task automatic load(input logic [63:0] p);
    for (int i = 0; i < 8; i++) wr(i, p[8*i+:8], 1'b1);
  endtask
  // spike at step n iff floor(n*v/256) advanced since step n-1
  function automatic logic [7:0] exp_vec(input int n);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = ((n * int'(vals[i])) / 256) != (((n - 1) * int'(vals[i])) / 256);
    return v;
  endfunction
  task automatic push_frame(input int n);
    logic [7:0] v;
    exp_total = 0;
    for (int k = 1; k <= n; k++) begin
      v = exp_vec(k);
      exp_q.push_back(v);
      exp_total += $countones(v);
    end
  endtask
  task automatic start_frame(input int n);
    num_steps = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget, input logic prev, input string name);
    bit   seen;
    logic pv;
    seen = 1'b0;
    pv = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else pv = out_spike_valid;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done within %0d cycles, expected one", name, budget);
    end else if (pv !== prev) begin
      miscompares++;
      $display("FAIL %s done_timing: strobe before done=%b, expected %b", name, pv, prev);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_width: done=%b second cycle, expected 0", name, done);
    end
    #1;
  endtask
  task automatic test_reset;
    repeat (3) tick();
    rst = 1'b0;
    settle();
    vectors++;
    if ({in_ready, busy, done, out_spike_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: ready/busy/done/valid=%b, expected 1000", {in_ready, busy, done, out_spike_valid});
    end
    vectors++;
    if ({out_spikes, step_count, frame_spikes} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: spikes=%h steps=%0d frame=%0d, expected 0", out_spikes, step_count, frame_spikes);
    end
    load({8'h20, 8'hFF, 8'hFF, 8'hC0, 8'h80, 8'h40, 8'h01, 8'h00});
    push_frame(50);
    start_frame(50);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, busy, done, out_spike_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL midreset_flags: ready/busy/done/valid=%b, expected 1000", {in_ready, busy, done, out_spike_valid});
    end
    vectors++;
    if ({out_spikes, step_count, frame_spikes} !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_regs: spikes=%h steps=%0d frame=%0d, expected 0", out_spikes, step_count, frame_spikes);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) vals[i] = '0;
    repeat (2) tick();
    rst = 1'b0;
    clear_counts();
    repeat (4) tick();
    settle();
    vectors++;
    if (done_cnt !== 0 || strobe_cnt !== 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: done=%0d strobes=%0d, expected 0 and 0", done_cnt, strobe_cnt);
    end
    push_frame(3);
    start_frame(3);
    wait_done(10, 1'b1, "midreset_frame");
    vectors++;
    if (frame_spikes !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset_values: frame_spikes=%0d, expected 0 (values cleared)", frame_spikes);
    end
  endtask
  task automatic test_rate;
    load({8'h20, 8'hFF, 8'hFF, 8'hC0, 8'h80, 8'h40, 8'h01, 8'h00});
    clear_counts();
    // num_steps is 8 bits, so 255 is the longest frame
    push_frame(255);
    start_frame(255);
    wait_done(300, 1'b1, "rate");
    vectors++;
    if (strobe_cnt !== 255) begin
      miscompares++;
      $display("FAIL rate_strobes: got %0d, expected 255", strobe_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ch_cnt[i] !== (255 * int'(vals[i])) / 256) begin
        miscompares++;
        $display("FAIL rate_ch%0d: got %0d spikes, expected %0d", i, ch_cnt[i], (255 * int'(vals[i])) / 256);
      end
    end
    vectors++;
    if (frame_spikes !== 16'd920 || exp_total != 920) begin
      miscompares++;
      $display("FAIL rate_frame: got %0d, expected 920", frame_spikes);
    end
    vectors++;
    if (step_count !== 8'd255 || done_cnt !== 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rate_end: steps=%0d done=%0d pending=%0d, expected 255 1 0", step_count, done_cnt, exp_q.size());
    end
  endtask
  task automatic test_pattern;
    load({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80});
    clear_counts();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    start_frame(4);
    wait_done(10, 1'b1, "pattern");
    vectors++;
    if (frame_spikes !== 16'd5 || step_count !== 8'd4) begin
      miscompares++;
      $display("FAIL pattern_totals: frame=%0d steps=%0d, expected 5 4", frame_spikes, step_count);
    end
    vectors++;
    if (out_spikes !== 8'h03) begin
      miscompares++;
      $display("FAIL pattern_hold: out_spikes=%b, expected 00000011", out_spikes);
    end
  endtask
  task automatic test_stall_abort;
    load({8'h20, 8'hFF, 8'hFF, 8'hC0, 8'h80, 8'h40, 8'h01, 8'h00});
    clear_counts();
    push_frame(10);
    start_frame(10);
    for (int c = 0; c < 20; c++) begin
      enable = (c % 2) == 0;
      tick();
    end
    enable = 1'b1;
    settle();
    vectors++;
    if (strobe_cnt !== 10 || busy !== 1'b0 || step_count !== 8'd10) begin
      miscompares++;
      $display("FAIL stall_steps: strobes=%0d busy=%b steps=%0d, expected 10 0 10", strobe_cnt, busy, step_count);
    end
    vectors++;
    if (done_cnt !== 1 || frame_spikes !== 16'(exp_total)) begin
      miscompares++;
      $display("FAIL stall_done: done=%0d frame=%0d, expected 1 %0d", done_cnt, frame_spikes, exp_total);
    end
    clear_counts();
    push_frame(3);
    start_frame(20);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    settle();
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || step_count !== 8'd3) begin
      miscompares++;
      $display("FAIL abort_state: busy=%b ready=%b steps=%0d, expected 0 1 3", busy, in_ready, step_count);
    end
    vectors++;
    if (strobe_cnt !== 3 || done_cnt !== 0 || frame_spikes !== 16'(exp_total) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_counts: strobes=%0d done=%0d frame=%0d, expected 3 0 %0d", strobe_cnt, done_cnt, frame_spikes, exp_total);
    end
    clear_counts();
    num_steps = 8'd5;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (2) tick();
    settle();
    vectors++;
    if (busy !== 1'b0 || strobe_cnt !== 0) begin
      miscompares++;
      $display("FAIL abort_beats_start: busy=%b strobes=%0d, expected 0 0", busy, strobe_cnt);
    end
  endtask
  task automatic test_edge;
    clear_counts();
    start_frame(0);
    wait_done(5, 1'b0, "zero_steps");
    vectors++;
    if (strobe_cnt !== 0 || step_count !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_steps: strobes=%0d steps=%0d, expected 0 0", strobe_cnt, step_count);
    end
    load({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80});
    push_frame(10);
    start_frame(10);
    tick();
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL encode_ready: ready=%b busy=%b, expected 0 1", in_ready, busy);
    end
    wr(0, 8'h07, 1'b0);
    wait_done(20, 1'b1, "write_during");
    push_frame(4);
    start_frame(4);
    wait_done(10, 1'b1, "value_kept");
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL value_kept: %0d vectors pending, expected 0", exp_q.size());
    end
  endtask
  task automatic test_back_to_back;
    clear_counts();
    in_valid = 1'b1;
    in_ch = 3'd2;
    in_data = 8'd200;
    num_steps = 8'd6;
    start = 1'b1;
    vals[2] = 8'd200;
    push_frame(6);
    tick();
    in_valid = 1'b0;
    start = 1'b0;
    tick();
    num_steps = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, 1'b1, "back_to_back");
    vectors++;
    if (step_count !== 8'd6 || strobe_cnt !== 6 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL start_ignored: steps=%0d strobes=%0d pending=%0d, expected 6 6 0", step_count, strobe_cnt, exp_q.size());
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      vals[i] = '0;
      ch_cnt[i] = 0;
    end
    test_reset();
    test_rate();
    test_pattern();
    test_stall_abort();
    test_edge();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
